// File: rtl/fitness_eval.sv
// Fitness evaluator: sweeps every input vector through the evolvable array and counts output bits matching the target ROM.
// Optional early abort on excessive mismatches is enabled by defining FIT_EARLY_ABORT_EN.
module fitness_eval #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 4,
  parameter int SCORE_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic [IN_W-1:0]    chromIn,
  input  logic [OUT_W-1:0]   chromOut,
  output logic [IN_W-1:0]    tgt_addr,
  input  logic [OUT_W-1:0]   tgt_data
`ifdef FIT_EARLY_ABORT_EN
  ,
  input  logic [SCORE_W-1:0] abort_thr,
  output logic               aborted
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'((2 ** IN_W) * OUT_W);

  state_t             state, state_next;
  logic [OUT_W-1:0]   out_q;
  logic               cmp_valid;
  logic [SCORE_W-1:0] score_next;
  logic               last_vec;
  logic               accept;
  logic               abort_hit;

  function automatic logic [SCORE_W-1:0] popcount(input logic [OUT_W-1:0] v);
    logic [SCORE_W-1:0] n;
    n = '0;
    for (int i = 0; i < OUT_W; i++) n = n + SCORE_W'(v[i]);
    return n;
  endfunction

  assign tgt_addr = chromIn;
  assign last_vec = (chromIn == {IN_W{1'b1}});
  assign accept   = (state == IDLE) && start;

  // out_q lags chromIn by one cycle, lining it up with the synchronous ROM word
  always_comb begin
    score_next = score;
    if (cmp_valid) score_next = score + popcount(~(out_q ^ tgt_data));
  end

`ifdef FIT_EARLY_ABORT_EN
  logic [SCORE_W-1:0] miss_cnt, miss_next;

  always_comb begin
    miss_next = miss_cnt;
    if (cmp_valid) miss_next = miss_cnt + popcount(out_q ^ tgt_data);
  end

  assign abort_hit = cmp_valid && (miss_next > abort_thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
      aborted  <= 1'b0;
    end else if (accept) begin
      miss_cnt <= '0;
      aborted  <= 1'b0;
    end else begin
      miss_cnt <= miss_next;
      if (abort_hit) aborted <= 1'b1;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (abort_hit)     state_next = DONE;
        else if (last_vec) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // An abort clears cmp_valid so the vector already captured in out_q is never scored
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chromIn   <= '0;
      out_q     <= '0;
      cmp_valid <= 1'b0;
      score     <= '0;
      perfect   <= 1'b0;
    end else begin
      state     <= state_next;
      out_q     <= chromOut;
      cmp_valid <= (state == RUN) && !abort_hit;
      if (accept) begin
        chromIn <= '0;
        score   <= '0;
        perfect <= 1'b0;
      end else begin
        if (state == RUN) chromIn <= abort_hit ? '0 : chromIn + 1'b1;
        score <= score_next;
        if (state == DRAIN || abort_hit)
          perfect <= !abort_hit && (score_next == FULL_SCORE);
      end
    end
  end

endmodule

// File: tb/tb_fitness_eval.sv
// Directed bench for fitness_eval: pass-through array model, testbench-owned synchronous target ROM.
// Define FIT_EARLY_ABORT_EN to also exercise the early-abort path.
module tb_fitness_eval;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, perfect;
  logic [10:0] score;
  logic [7:0]  chromIn, tgt_addr;
  logic [3:0]  chromOut, tgt_data;
  logic [3:0]  rom [256];
`ifdef FIT_EARLY_ABORT_EN
  logic [10:0] abort_thr = 11'h7FF;
  logic        aborted;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  fitness_eval dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .score(score), .perfect(perfect), .chromIn(chromIn), .chromOut(chromOut),
    .tgt_addr(tgt_addr), .tgt_data(tgt_data)
`ifdef FIT_EARLY_ABORT_EN
    , .abort_thr(abort_thr), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Array under test is a pass-through of the low nibble; ROM answers one cycle after the address
  assign chromOut = chromIn[3:0];
  always @(posedge clk) tgt_data <= rom[tgt_addr];

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic loadRom(input int mode);
    for (int v = 0; v < 256; v++) begin
      logic [7:0] a;
      a = 8'(v);
      case (mode)
        1:       rom[v] = ~a[3:0];
        2:       rom[v] = (a == 8'h5A) ? (a[3:0] ^ 4'b0100) : a[3:0];
        default: rom[v] = a[3:0];
      endcase
    end
  endtask

  task automatic pulseStart(input string tag, output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy_t1"}, busy, 1);
    checkOutput({tag, "_chromIn_t1"}, chromIn, 0);
    checkOutput({tag, "_score_t1"}, score, 0);
    checkOutput({tag, "_done_t1"}, done, 0);
  endtask

  task automatic waitDone(input string tag, input int t0, input int mid_pulse, output int lat);
    lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      @(negedge clk);
      start = (mid_pulse > 0) && (cyc - t0 == mid_pulse);
      if (cyc - t0 == 11) begin
        checkOutput({tag, "_chromIn_mid"}, chromIn, 10);
        checkOutput({tag, "_tgt_addr_mid"}, tgt_addr, 10);
      end
      if (cyc - t0 == 257) checkOutput({tag, "_busy_drain"}, busy, 1);
      if (done) lat = cyc - t0;
    end
    start = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input int exp_lat, input int exp_score,
                               input int exp_perfect, input int exp_aborted);
    int t0, lat;
    pulseStart(tag, t0);
    waitDone(tag, t0, 0, lat);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_score"}, score, exp_score);
    checkOutput({tag, "_perfect"}, perfect, exp_perfect);
    checkOutput({tag, "_busy_done"}, busy, 0);
`ifdef FIT_EARLY_ABORT_EN
    checkOutput({tag, "_aborted"}, aborted, exp_aborted);
`else
    if (exp_aborted != 0) $display("[TB] note: abort expected but feature not built");
`endif
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, done, 0);
    checkOutput({tag, "_score_held"}, score, exp_score);
  endtask

  initial begin
    int t0, t1, lat, done_seen;
    loadRom(0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_score", score, 0);
    checkOutput("rst_perfect", perfect, 0);
    checkOutput("rst_chromIn", chromIn, 0);
    checkOutput("rst_tgt_addr", tgt_addr, 0);
`ifdef FIT_EARLY_ABORT_EN
    checkOutput("rst_aborted", aborted, 0);
`endif
    rst = 1'b0;

    loadRom(0);
    applyStimulus("t1", 258, 1024, 1, 0);
    loadRom(1);
    applyStimulus("t2", 258, 0, 0, 0);
    loadRom(2);
    applyStimulus("t3", 258, 1023, 0, 0);

    // Start mid-sweep must be ignored; start right after done begins a fresh sweep
    loadRom(0);
    pulseStart("t4a", t0);
    waitDone("t4a", t0, 50, lat);
    checkOutput("t4a_latency", lat, 258);
    checkOutput("t4a_score", score, 1024);
    pulseStart("t4b", t1);
    checkOutput("t4b_restart_cycle", t1 - t0, 259);
    waitDone("t4b", t1, 0, lat);
    checkOutput("t4b_latency", lat, 258);
    checkOutput("t4b_score", score, 1024);
    checkOutput("t4b_perfect", perfect, 1);

    // Reset mid-sweep: 98 compares land by t0+100, then everything clears
    pulseStart("t5", t0);
    repeat (99) @(negedge clk);
    checkOutput("t5_partial_score", score, 392);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_score", score, 0);
    checkOutput("t5_chromIn", chromIn, 0);
    checkOutput("t5_done", done, 0);
    rst = 1'b0;
    done_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("t5_no_done", done_seen, 0);
    checkOutput("t5_busy_after", busy, 0);

`ifdef FIT_EARLY_ABORT_EN
    loadRom(1);
    abort_thr = 11'd3;
    applyStimulus("t6", 3, 0, 0, 1);
    abort_thr = 11'h7FF;
    loadRom(0);
    applyStimulus("t7", 258, 1024, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
